// File: rtl/quad_decoder_array.sv
// Multi-channel quadrature encoder front end: per channel a 2-flop synchroniser, a joint
// debounce on the {B,A} pair and a quarter-step decoder driving a position counter.
module quad_decoder_array #(
  parameter int N_CH      = 2,
  parameter int POS_W     = 8,
  parameter int DB_CYCLES = 1024,
  parameter int COUNT_PER = 4,
  parameter int SATURATE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*N_CH-1:0]       quad_in,
  input  logic [N_CH-1:0]         clear,
  input  logic [N_CH-1:0]         err_clr,
  output logic [N_CH*POS_W-1:0]   pos_out,
  output logic [N_CH-1:0]         step_cw,
  output logic [N_CH-1:0]         step_ccw,
  output logic [N_CH-1:0]         err
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int Q_W   = $clog2(COUNT_PER + 1) + 1;
  localparam logic [CNT_W-1:0]    DB_LIMIT = CNT_W'(DB_CYCLES);
  localparam logic signed [Q_W-1:0] Q_ONE = Q_W'(1);
  localparam logic signed [Q_W-1:0] Q_POS = Q_W'(COUNT_PER);
  localparam logic signed [Q_W-1:0] Q_NEG = -Q_POS;

  // Position of a {B,A} state along the CW cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ba);
    case (ba)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]             acc_q, acc_d, old_q, old_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   upd_q, upd_d, silent_q, silent_d, init_q, init_d;
    logic signed [Q_W-1:0]  q_q, q_d, q_next;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   cw_q, cw_d, ccw_q, ccw_d, err_q, err_d;
    logic [1:0]             idx_inc;
    logic                   is_cw, illegal;

    assign sync1_d = quad_in[2*i +: 2];
    assign sync2_d = sync1_q;

    // While init is set the first settled pin state is accepted even if it equals the
    // reset value, so init always clears and that adoption is flagged silent.
    always_comb begin
      // NOTE: every variable gets a default first, so no path through the block infers a latch.
      acc_d    = acc_q;
      old_d    = old_q;
      upd_d    = 1'b0;
      silent_d = silent_q;
      init_d   = init_q;
      cnt_d    = cnt_q;
      if (sync1_q != sync2_q || (sync2_q == acc_q && !init_q)) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LIMIT) begin
        acc_d    = sync2_q;
        old_d    = acc_q;
        upd_d    = 1'b1;
        silent_d = init_q;
        init_d   = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    assign idx_inc = gray_idx(old_q) + 2'd1;
    assign is_cw   = (gray_idx(acc_q) == idx_inc);
    assign illegal = ((old_q ^ acc_q) == 2'b11);

    always_comb begin
      q_next = q_q;
      q_d    = q_q;
      pos_d  = pos_q;
      cw_d   = 1'b0;
      ccw_d  = 1'b0;
      err_d  = err_q & ~err_clr[i];
      if (upd_q && !silent_q) begin
        if (illegal) begin
          err_d = 1'b1;
        end else begin
          q_next = is_cw ? (q_q + Q_ONE) : (q_q - Q_ONE);
          q_d    = q_next;
          if (q_next == Q_POS) begin
            q_d  = '0;
            cw_d = 1'b1;
            if (SATURATE == 0 || pos_q != '1) pos_d = pos_q + 1'b1;
          end else if (q_next == Q_NEG) begin
            q_d   = '0;
            ccw_d = 1'b1;
            if (SATURATE == 0 || pos_q != '0) pos_d = pos_q - 1'b1;
          end
        end
      end
      if (clear[i]) begin
        pos_d = '0;
        q_d   = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q  <= '0;
        sync2_q  <= '0;
        acc_q    <= '0;
        old_q    <= '0;
        cnt_q    <= '0;
        upd_q    <= 1'b0;
        silent_q <= 1'b0;
        init_q   <= 1'b1;
        q_q      <= '0;
        pos_q    <= '0;
        cw_q     <= 1'b0;
        ccw_q    <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        acc_q    <= acc_d;
        old_q    <= old_d;
        cnt_q    <= cnt_d;
        upd_q    <= upd_d;
        silent_q <= silent_d;
        init_q   <= init_d;
        q_q      <= q_d;
        pos_q    <= pos_d;
        cw_q     <= cw_d;
        ccw_q    <= ccw_d;
        err_q    <= err_d;
      end
    end

    assign pos_out[i*POS_W +: POS_W] = pos_q;
    assign step_cw[i]  = cw_q;
    assign step_ccw[i] = ccw_q;
    assign err[i]      = err_q;
  end

endmodule

// File: tb/tb_quad_decoder_array.sv
// Directed bench for quad_decoder_array (N_CH=2, POS_W=8, DB_CYCLES=4, COUNT_PER=4), with a
// second SATURATE=1 instance sharing the stimulus for the clamp case.
module tb_quad_decoder_array;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  quad_in = '0;
  logic [1:0]  clear = '0;
  logic [1:0]  err_clr = '0;
  logic [15:0] pos_out, pos_out_s;
  logic [1:0]  step_cw, step_ccw, err, step_cw_s, step_ccw_s, err_s;

  int compared = 0;
  int mismatched = 0;
  int cw_seen [2] = '{0, 0};
  int ccw_seen [2] = '{0, 0};
  int overlap = 0;
  int snap_cw0, snap_ccw0, snap_cw1;

  always #5 clk = ~clk;

  quad_decoder_array #(.N_CH(2), .POS_W(8), .DB_CYCLES(4), .COUNT_PER(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .quad_in(quad_in), .clear(clear), .err_clr(err_clr),
    .pos_out(pos_out), .step_cw(step_cw), .step_ccw(step_ccw), .err(err)
  );

  quad_decoder_array #(.N_CH(2), .POS_W(8), .DB_CYCLES(4), .COUNT_PER(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .quad_in(quad_in), .clear(clear), .err_clr(err_clr),
    .pos_out(pos_out_s), .step_cw(step_cw_s), .step_ccw(step_ccw_s), .err(err_s)
  );

  // Cycles with a step pulse high; a pulse wider than one cycle inflates the count.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (step_cw[c])  cw_seen[c]  <= cw_seen[c] + 1;
      if (step_ccw[c]) ccw_seen[c] <= ccw_seen[c] + 1;
    end
    if ((step_cw & step_ccw) != 2'b00) overlap <= overlap + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] v);
    quad_in[2*ch +: 2] = v;
  endtask

  task automatic hold(input int ch, input logic [1:0] v, input int n);
    set_ch(ch, v);
    tick(n);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_pos", pos_out, 32'h0);
    check("rst_cw", step_cw, 32'h0);
    check("rst_ccw", step_ccw, 32'h0);
    check("rst_err", err, 32'h0);
    check("rst_pos_sat", pos_out_s, 32'h0);
    rst = 1'b0;
    tick(20);

    // 1: one CW detent on ch0, pulse lands 8 sample points after the last pin edge
    hold(0, 2'b01, 10);
    hold(0, 2'b11, 10);
    hold(0, 2'b10, 10);
    hold(0, 2'b00, 7);
    check("t1_pre_cw", step_cw, 32'h0);
    check("t1_pre_pos", pos_out, 32'h0);
    tick(1);
    check("t1_cw", step_cw, 32'h1);
    check("t1_pos", pos_out, 32'h0001);
    check("t1_ccw", step_ccw, 32'h0);
    tick(1);
    check("t1_cw_width", step_cw, 32'h0);

    // 2: 3-clk glitch is filtered; a held 01 is accepted as q=+1 and completes a detent
    set_ch(0, 2'b01);
    tick(3);
    set_ch(0, 2'b00);
    tick(15);
    check("t2_glitch_pos", pos_out, 32'h0001);
    check("t2_glitch_err", err, 32'h0);
    check("t2_glitch_steps", cw_seen[0], 32'd1);
    hold(0, 2'b01, 10);
    check("t2_q1_pos", pos_out, 32'h0001);
    hold(0, 2'b11, 10);
    hold(0, 2'b10, 10);
    hold(0, 2'b00, 7);
    check("t2_pre_pos", pos_out, 32'h0001);
    tick(1);
    check("t2_cw", step_cw, 32'h1);
    check("t2_pos", pos_out, 32'h0002);
    tick(2);

    // 3: CCW detent on ch1 from reset: wraps to 255, clamps at 0 when saturating
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("t3_rst_pos", pos_out, 32'h0);
    hold(1, 2'b10, 10);
    hold(1, 2'b11, 10);
    hold(1, 2'b01, 10);
    hold(1, 2'b00, 7);
    check("t3_pre_ccw", step_ccw, 32'h0);
    tick(1);
    check("t3_ccw", step_ccw, 32'h2);
    check("t3_pos", pos_out, 32'hFF00);
    check("t3_sat_ccw", step_ccw_s, 32'h2);
    check("t3_sat_cw", step_cw_s, 32'h0);
    check("t3_sat_pos", pos_out_s, 32'h0);
    check("t3_sat_err", err_s, 32'h0);
    tick(1);
    check("t3_ccw_width", step_ccw, 32'h0);

    // 4: illegal edge sets err; err_clr clears it; set wins over a coincident clear
    hold(0, 2'b11, 10);
    check("t4_err", err, 32'h1);
    check("t4_pos", pos_out, 32'hFF00);
    err_clr = 2'b01;
    tick(1);
    err_clr = 2'b00;
    check("t4_err_clr", err, 32'h0);
    set_ch(0, 2'b00);
    tick(7);
    err_clr = 2'b01;
    tick(1);
    err_clr = 2'b00;
    check("t4_set_wins", err, 32'h1);
    tick(2);

    // 5: five clean detents (q must be 0 after the illegal edges), then clear on the 6th step
    for (int d = 0; d < 5; d++) begin
      hold(0, 2'b01, 10);
      hold(0, 2'b11, 10);
      hold(0, 2'b10, 10);
      hold(0, 2'b00, 10);
    end
    check("t5_pos5", pos_out, 32'hFF05);
    hold(0, 2'b01, 10);
    hold(0, 2'b11, 10);
    hold(0, 2'b10, 10);
    set_ch(0, 2'b00);
    tick(7);
    clear = 2'b01;
    tick(1);
    clear = 2'b00;
    check("t5_pos_clr", pos_out, 32'hFF00);
    check("t5_cw", step_cw, 32'h1);
    tick(3);

    // 6: reset mid-rotation with pins at 11; silent adoption, then counting resumes from there
    hold(0, 2'b01, 10);
    hold(0, 2'b11, 10);
    snap_cw0  = cw_seen[0];
    snap_ccw0 = ccw_seen[0];
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("t6_err", err, 32'h0);
    check("t6_pos", pos_out, 32'h0);
    check("t6_no_step", (cw_seen[0] - snap_cw0) + (ccw_seen[0] - snap_ccw0), 32'd0);
    hold(0, 2'b10, 10);
    hold(0, 2'b00, 10);
    check("t6_q2_pos", pos_out, 32'h0);
    hold(0, 2'b01, 10);
    hold(0, 2'b11, 10);
    check("t6_pos1", pos_out, 32'h0001);
    check("t6_steps", cw_seen[0] - snap_cw0, 32'd1);

    // 7: both channels rotate CW together for three detents
    rst = 1'b1;
    quad_in = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(20);
    snap_cw0 = cw_seen[0];
    snap_cw1 = cw_seen[1];
    for (int d = 0; d < 3; d++) begin
      quad_in = 4'b0101;
      tick(10);
      quad_in = 4'b1111;
      tick(10);
      quad_in = 4'b1010;
      tick(10);
      quad_in = 4'b0000;
      tick(7);
      check("t7_pre_cw", step_cw, 32'h0);
      tick(1);
      check("t7_cw_both", step_cw, 32'h3);
      tick(2);
    end
    check("t7_pos", pos_out, 32'h0303);
    check("t7_cnt0", cw_seen[0] - snap_cw0, 32'd3);
    check("t7_cnt1", cw_seen[1] - snap_cw1, 32'd3);
    check("overlap", overlap, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
